// File: rtl/noc_input_port.sv
// NoC router input port: one FIFO and one packet state machine per virtual channel.
// Define INPUT_PORT_ASSERTIONS_EN to compile in protocol-violation assertions.
package noc_params;
  localparam int MESH_SIZE_X      = 4;
  localparam int MESH_SIZE_Y      = 4;
  localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
  localparam int VC_NUM           = 4;
  localparam int VC_SIZE          = $clog2(VC_NUM);
  localparam int FLIT_DATA_SIZE   = 12;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    flit_label_t                 flit_label;
    logic [VC_SIZE-1:0]          vc_id;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [FLIT_DATA_SIZE-1:0]   payload;
  } flit_t;
endpackage

module noc_input_port
  import noc_params::*;
#(
  parameter int BUFFER_SIZE    = 8,
  parameter int PIPELINE_DEPTH = 5,
  parameter int X_CURRENT      = MESH_SIZE_X / 2,
  parameter int Y_CURRENT      = MESH_SIZE_Y / 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  flit_t                           data_i,
  input  logic                            valid_flit_i,
  input  logic [VC_SIZE-1:0]              vc_sel_i,
  input  logic                            valid_sel_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]  vc_new_i,
  input  logic [VC_NUM-1:0]               vc_valid_i,
  output flit_t                           flit_o,
  output logic [VC_NUM-1:0]               on_off_o,
  output logic [VC_NUM-1:0]               vc_allocatable_o,
  output logic [VC_NUM-1:0]               vc_request_o,
  output port_t [VC_NUM-1:0]              out_port_o,
  output logic [VC_NUM-1:0]               is_full_o,
  output logic [VC_NUM-1:0]               is_empty_o
);
  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

  typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

  vc_state_t          state_q  [VC_NUM];
  vc_state_t          state_d  [VC_NUM];
  logic [PTR_W-1:0]   rd_ptr_q [VC_NUM];
  logic [PTR_W-1:0]   rd_ptr_d [VC_NUM];
  logic [PTR_W-1:0]   wr_ptr_q [VC_NUM];
  logic [PTR_W-1:0]   wr_ptr_d [VC_NUM];
  logic [CNT_W-1:0]   cnt_q    [VC_NUM];
  logic [CNT_W-1:0]   cnt_d    [VC_NUM];
  logic [VC_SIZE-1:0] dvc_q    [VC_NUM];
  logic [VC_SIZE-1:0] dvc_d    [VC_NUM];
  port_t              port_q   [VC_NUM];
  port_t              port_d   [VC_NUM];
  flit_t              mem_q    [VC_NUM][BUFFER_SIZE];
  logic [VC_NUM-1:0]  hit;
  logic [VC_NUM-1:0]  push;
  logic [VC_NUM-1:0]  pop;
  logic               head_in;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic port_t xy_route(input logic [DEST_ADDR_SIZE_X-1:0] x,
                                     input logic [DEST_ADDR_SIZE_Y-1:0] y);
    if (int'(x) > X_CURRENT) return EAST;
    if (int'(x) < X_CURRENT) return WEST;
    if (int'(y) > Y_CURRENT) return SOUTH;
    if (int'(y) < Y_CURRENT) return NORTH;
    return LOCAL;
  endfunction

  always_comb begin
    head_in = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
    flit_o  = '0;
    if (valid_sel_i && (cnt_q[vc_sel_i] != '0)) begin
      flit_o       = mem_q[vc_sel_i][rd_ptr_q[vc_sel_i]];
      flit_o.vc_id = dvc_q[vc_sel_i];
    end
    for (int v = 0; v < VC_NUM; v++) begin
      hit[v]  = valid_flit_i && (data_i.vc_id == VC_SIZE'(v));
      pop[v]  = valid_sel_i && (vc_sel_i == VC_SIZE'(v)) &&
                (state_q[v] == ACTIVE) && (cnt_q[v] != '0);
      // IDLE admits only heads; a packet in flight admits only non-heads.
      push[v] = hit[v] && ((state_q[v] == IDLE) == head_in) &&
                ((cnt_q[v] != CNT_W'(BUFFER_SIZE)) || pop[v]);

      state_d[v]  = state_q[v];
      dvc_d[v]    = dvc_q[v];
      port_d[v]   = port_q[v];
      rd_ptr_d[v] = pop[v]  ? next_ptr(rd_ptr_q[v]) : rd_ptr_q[v];
      wr_ptr_d[v] = push[v] ? next_ptr(wr_ptr_q[v]) : wr_ptr_q[v];
      cnt_d[v]    = cnt_q[v];
      if (push[v] && !pop[v]) cnt_d[v] = cnt_q[v] + 1'b1;
      if (pop[v] && !push[v]) cnt_d[v] = cnt_q[v] - 1'b1;

      case (state_q[v])
        IDLE: if (push[v]) begin
          state_d[v] = VA;
          port_d[v]  = xy_route(data_i.x_dest, data_i.y_dest);
        end
        VA: if (vc_valid_i[v]) begin
          state_d[v] = ACTIVE;
          dvc_d[v]   = vc_new_i[v];
        end
        ACTIVE: if (pop[v] && ((mem_q[v][rd_ptr_q[v]].flit_label == TAIL) ||
                               (mem_q[v][rd_ptr_q[v]].flit_label == HEADTAIL))) begin
          state_d[v] = IDLE;
          port_d[v]  = LOCAL;
        end
        default: state_d[v] = IDLE;
      endcase

      is_empty_o[v]       = (cnt_q[v] == '0);
      is_full_o[v]        = (cnt_q[v] == CNT_W'(BUFFER_SIZE));
      on_off_o[v]         = (BUFFER_SIZE - int'(cnt_q[v])) >= PIPELINE_DEPTH;
      vc_allocatable_o[v] = (state_q[v] == IDLE);
      vc_request_o[v]     = (state_q[v] == VA);
      out_port_o[v]       = port_q[v];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v]  <= IDLE;
        rd_ptr_q[v] <= '0;
        wr_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
        dvc_q[v]    <= '0;
        port_q[v]   <= LOCAL;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v]  <= state_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        wr_ptr_q[v] <= wr_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
        dvc_q[v]    <= dvc_d[v];
        port_q[v]   <= port_d[v];
      end
    end
  end

  // Flit storage carries no reset; the pointers and counts define validity.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (push[v]) mem_q[v][wr_ptr_q[v]] <= data_i;
    end
  end

`ifdef INPUT_PORT_ASSERTIONS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        assert (!(hit[v] && (cnt_q[v] == CNT_W'(BUFFER_SIZE)) && !pop[v]))
          else $error("input_port: write to full FIFO on VC %0d", v);
        assert (!(hit[v] && (state_q[v] == IDLE) && !head_in))
          else $error("input_port: BODY/TAIL written to IDLE VC %0d", v);
        assert (!(vc_valid_i[v] && (state_q[v] != VA)))
          else $error("input_port: vc_valid_i outside VA on VC %0d", v);
      end
      assert (!(valid_sel_i && ((state_q[vc_sel_i] != ACTIVE) || (cnt_q[vc_sel_i] == '0))))
        else $error("input_port: valid_sel_i on empty or non-ACTIVE VC %0d", vc_sel_i);
    end
  end
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Self-checking bench for noc_input_port: queue-based reference model plus directed packet scenarios.
`timescale 1ns/1ps
module tb_noc_input_port;
  import noc_params::*;

  localparam int BS = 8;
  localparam int PD = 5;
  localparam int XC = MESH_SIZE_X / 2;
  localparam int YC = MESH_SIZE_Y / 2;
  localparam int S_IDLE = 0, S_VA = 1, S_ACT = 2;

  logic                           clk = 1'b0;
  logic                           rst = 1'b0;
  flit_t                          data_i;
  logic                           valid_flit_i;
  logic [VC_SIZE-1:0]             vc_sel_i;
  logic                           valid_sel_i;
  logic [VC_NUM-1:0][VC_SIZE-1:0] vc_new_i;
  logic [VC_NUM-1:0]              vc_valid_i;
  flit_t                          flit_o;
  logic [VC_NUM-1:0]              on_off_o, vc_allocatable_o, vc_request_o, is_full_o, is_empty_o;
  port_t [VC_NUM-1:0]             out_port_o;

  noc_input_port #(.BUFFER_SIZE(BS), .PIPELINE_DEPTH(PD), .X_CURRENT(XC), .Y_CURRENT(YC)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_flit_i(valid_flit_i),
    .vc_sel_i(vc_sel_i), .valid_sel_i(valid_sel_i), .vc_new_i(vc_new_i),
    .vc_valid_i(vc_valid_i), .flit_o(flit_o), .on_off_o(on_off_o),
    .vc_allocatable_o(vc_allocatable_o), .vc_request_o(vc_request_o),
    .out_port_o(out_port_o), .is_full_o(is_full_o), .is_empty_o(is_empty_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  flit_t              mq  [VC_NUM][$];
  int                 mst [VC_NUM];
  logic [VC_SIZE-1:0] mvc [VC_NUM];
  port_t              mrt [VC_NUM];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic flit_t mk(input flit_label_t l, input int vc, input int x, input int y, input int pl);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = VC_SIZE'(vc);
    f.x_dest     = DEST_ADDR_SIZE_X'(x);
    f.y_dest     = DEST_ADDR_SIZE_Y'(y);
    f.payload    = FLIT_DATA_SIZE'(pl);
    return f;
  endfunction

  function automatic port_t route(input flit_t f);
    if (f.x_dest > XC) return EAST;
    if (f.x_dest < XC) return WEST;
    if (f.y_dest > YC) return SOUTH;
    if (f.y_dest < YC) return NORTH;
    return LOCAL;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VC_NUM; v++) begin
      mq[v].delete();
      mst[v] = S_IDLE;
      mvc[v] = '0;
      mrt[v] = LOCAL;
    end
  endtask

  task automatic model_check();
    flit_t ef;
    int s;
    for (int v = 0; v < VC_NUM; v++) begin
      chk($sformatf("is_empty[%0d]", v), 32'(is_empty_o[v]), 32'(mq[v].size() == 0));
      chk($sformatf("is_full[%0d]", v), 32'(is_full_o[v]), 32'(mq[v].size() == BS));
      chk($sformatf("on_off[%0d]", v), 32'(on_off_o[v]), 32'((BS - mq[v].size()) >= PD));
      chk($sformatf("allocatable[%0d]", v), 32'(vc_allocatable_o[v]), 32'(mst[v] == S_IDLE));
      chk($sformatf("vc_request[%0d]", v), 32'(vc_request_o[v]), 32'(mst[v] == S_VA));
      if (mst[v] != S_IDLE || !rst)
        chk($sformatf("out_port[%0d]", v), 32'(out_port_o[v]), 32'(mrt[v]));
    end
    s = int'(vc_sel_i);
    if (valid_sel_i && mq[s].size() > 0) begin
      ef = mq[s][0];
      chk("flit_fields", {flit_o.flit_label, flit_o.x_dest, flit_o.y_dest, flit_o.payload},
          {ef.flit_label, ef.x_dest, ef.y_dest, ef.payload});
      if (mst[s] == S_ACT) chk("flit_vc", 32'(flit_o.vc_id), 32'(mvc[s]));
    end else begin
      chk("flit_zero", 32'(flit_o), 32'(0));
    end
  endtask

  task automatic model_update();
    int    s, v, old[VC_NUM];
    bit    popped, acc, hd;
    flit_t f;
    if (!rst) begin
      model_reset();
      return;
    end
    s = int'(vc_sel_i);
    v = int'(data_i.vc_id);
    for (int w = 0; w < VC_NUM; w++) old[w] = mst[w];
    popped = valid_sel_i && old[s] == S_ACT && mq[s].size() > 0;
    hd  = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
    acc = valid_flit_i && ((old[v] == S_IDLE) == hd) &&
          (mq[v].size() < BS || (popped && s == v));
    if (popped) begin
      f = mq[s].pop_front();
      if (f.flit_label == TAIL || f.flit_label == HEADTAIL) begin
        mst[s] = S_IDLE;
        mrt[s] = LOCAL;
      end
    end
    if (acc) begin
      mq[v].push_back(data_i);
      if (old[v] == S_IDLE) begin
        mst[v] = S_VA;
        mrt[v] = route(data_i);
      end
    end
    for (int w = 0; w < VC_NUM; w++)
      if (old[w] == S_VA && vc_valid_i[w]) begin
        mst[w] = S_ACT;
        mvc[w] = vc_new_i[w];
      end
  endtask

  task automatic tick_check();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick_adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    data_i       = '0;
    valid_flit_i = 1'b0;
    vc_sel_i     = '0;
    valid_sel_i  = 1'b0;
    vc_new_i     = '0;
    vc_valid_i   = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      clear_inputs();
      tick_check();
      tick_adv();
    end
  endtask

  task automatic random_phase(input int n, input int wr_pct, input int rd_pct);
    flit_t f;
    for (int i = 0; i < n; i++) begin
      clear_inputs();
      valid_flit_i = ($urandom_range(0, 99) < wr_pct);
      f.flit_label = flit_label_t'($urandom_range(0, 3));
      f.vc_id      = VC_SIZE'($urandom_range(0, VC_NUM - 1));
      f.x_dest     = DEST_ADDR_SIZE_X'($urandom_range(0, MESH_SIZE_X - 1));
      f.y_dest     = DEST_ADDR_SIZE_Y'($urandom_range(0, MESH_SIZE_Y - 1));
      f.payload    = FLIT_DATA_SIZE'($urandom);
      data_i       = f;
      valid_sel_i  = ($urandom_range(0, 99) < rd_pct);
      vc_sel_i     = VC_SIZE'($urandom_range(0, VC_NUM - 1));
      for (int v = 0; v < VC_NUM; v++) begin
        vc_valid_i[v] = ($urandom_range(0, 99) < 25);
        vc_new_i[v]   = VC_SIZE'($urandom_range(0, VC_NUM - 1));
      end
      tick_check();
      tick_adv();
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b0;
    valid_sel_i = 1'b1;
    tick_check();
    chk("rst_flit", 32'(flit_o), 32'(0));
    chk("rst_empty", 32'(is_empty_o), 32'({VC_NUM{1'b1}}));
    chk("rst_onoff", 32'(on_off_o), 32'({VC_NUM{1'b1}}));
    chk("rst_alloc", 32'(vc_allocatable_o), 32'({VC_NUM{1'b1}}));
    chk("rst_req", 32'(vc_request_o), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(2);

    // 4-flit packet on VC1, downstream VC 3.
    for (int i = 0; i < 9; i++) begin
      clear_inputs();
      if (i == 0) begin valid_flit_i = 1'b1; data_i = mk(HEAD, 1, 3, 0, 'h101); end
      if (i == 1) begin valid_flit_i = 1'b1; data_i = mk(BODY, 1, 0, 0, 'h102); end
      if (i == 2) begin valid_flit_i = 1'b1; data_i = mk(BODY, 1, 0, 0, 'h103);
                        vc_valid_i[1] = 1'b1; vc_new_i[1] = 2'd3; end
      if (i == 3) begin valid_flit_i = 1'b1; data_i = mk(TAIL, 1, 0, 0, 'h104); end
      if (i >= 4 && i <= 7) begin valid_sel_i = 1'b1; vc_sel_i = 2'd1; end
      tick_check();
      if (i == 1) begin
        chk("t1_req", 32'(vc_request_o[1]), 32'(1));
        chk("t1_port", 32'(out_port_o[1]), 32'(EAST));
      end
      if (i == 4) chk("t1_f0", 32'(flit_o), 32'(mk(HEAD, 3, 3, 0, 'h101)));
      if (i == 5) chk("t1_f1", 32'(flit_o), 32'(mk(BODY, 3, 0, 0, 'h102)));
      if (i == 6) chk("t1_f2", 32'(flit_o), 32'(mk(BODY, 3, 0, 0, 'h103)));
      if (i == 7) chk("t1_f3", 32'(flit_o), 32'(mk(TAIL, 3, 0, 0, 'h104)));
      if (i == 8) begin
        chk("t1_alloc", 32'(vc_allocatable_o[1]), 32'(1));
        chk("t1_empty", 32'(is_empty_o[1]), 32'(1));
      end
      tick_adv();
    end

    // HEAD + TAIL on VC0, VA at cycle 1.
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      if (i == 0) begin valid_flit_i = 1'b1; data_i = mk(HEAD, 0, 1, 2, 'h0A1); end
      if (i == 1) begin valid_flit_i = 1'b1; data_i = mk(TAIL, 0, 0, 0, 'h0A2);
                        vc_valid_i[0] = 1'b1; vc_new_i[0] = 2'd2; end
      if (i == 2 || i == 3) begin valid_sel_i = 1'b1; vc_sel_i = 2'd0; end
      tick_check();
      if (i == 1) chk("t2_port", 32'(out_port_o[0]), 32'(WEST));
      if (i == 2) chk("t2_f0", 32'(flit_o), 32'(mk(HEAD, 2, 1, 2, 'h0A1)));
      if (i == 3) begin
        chk("t2_f1", 32'(flit_o), 32'(mk(TAIL, 2, 0, 0, 'h0A2)));
        chk("t2_busy", 32'(vc_allocatable_o[0]), 32'(0));
      end
      if (i == 4) chk("t2_alloc", 32'(vc_allocatable_o[0]), 32'(1));
      tick_adv();
    end

    // 16-flit packet streamed through an 8-deep FIFO on VC2.
    for (int i = 0; i < 19; i++) begin
      clear_inputs();
      if (i < 16) begin
        valid_flit_i = 1'b1;
        data_i = mk((i == 0) ? HEAD : ((i == 15) ? TAIL : BODY), 2, 2, 2, i);
      end
      if (i == 1) begin vc_valid_i[2] = 1'b1; vc_new_i[2] = 2'd1; end
      if (i >= 2 && i <= 17) begin valid_sel_i = 1'b1; vc_sel_i = 2'd2; end
      tick_check();
      if (i >= 2 && i <= 17) begin
        chk("t3_label", 32'(flit_o.flit_label),
            32'((i == 2) ? HEAD : ((i == 17) ? TAIL : BODY)));
        chk("t3_payload", 32'(flit_o.payload), 32'(i - 2));
        chk("t3_vc", 32'(flit_o.vc_id), 32'(1));
      end
      chk("t3_onoff", 32'(on_off_o[2]), 32'(1));
      if (i == 18) chk("t3_alloc", 32'(vc_allocatable_o[2]), 32'(1));
      tick_adv();
    end

    // Three leading HEADs on VC3: only the first is kept.
    for (int i = 0; i < 11; i++) begin
      clear_inputs();
      if (i <= 2) begin valid_flit_i = 1'b1; data_i = mk(HEAD, 3, 2, 3, 'hA0 + i); end
      if (i == 3 || i == 4) begin valid_flit_i = 1'b1; data_i = mk(BODY, 3, 0, 0, 'hA0 + i); end
      if (i == 5) begin valid_flit_i = 1'b1; data_i = mk(TAIL, 3, 0, 0, 'hA5); end
      if (i == 1) begin vc_valid_i[3] = 1'b1; vc_new_i[3] = 2'd0; end
      if (i >= 6) begin valid_sel_i = 1'b1; vc_sel_i = 2'd3; end
      tick_check();
      if (i == 1) chk("t4_port", 32'(out_port_o[3]), 32'(SOUTH));
      if (i == 6) chk("t4_f0", 32'(flit_o.payload), 32'('hA0));
      if (i == 7) chk("t4_f1", 32'(flit_o.payload), 32'('hA3));
      if (i == 8) chk("t4_f2", 32'(flit_o.payload), 32'('hA4));
      if (i == 9) chk("t4_f3", 32'(flit_o), 32'(mk(TAIL, 0, 0, 0, 'hA5)));
      if (i == 10) chk("t4_drained", 32'(flit_o), 32'(0));
      tick_adv();
    end

    // Single HEADTAIL on VC1.
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      if (i == 0) begin valid_flit_i = 1'b1; data_i = mk(HEADTAIL, 1, 2, 1, 'h3C3); end
      if (i == 1) begin vc_valid_i[1] = 1'b1; vc_new_i[1] = 2'd2; end
      if (i == 2) begin valid_sel_i = 1'b1; vc_sel_i = 2'd1; end
      tick_check();
      if (i == 1) chk("t5_port", 32'(out_port_o[1]), 32'(NORTH));
      if (i == 2) chk("t5_f0", 32'(flit_o), 32'(mk(HEADTAIL, 2, 2, 1, 'h3C3)));
      if (i == 3) begin
        chk("t5_alloc", 32'(vc_allocatable_o[1]), 32'(1));
        chk("t5_empty", 32'(is_empty_o[1]), 32'(1));
      end
      tick_adv();
    end

    // BODY then TAIL to an IDLE VC are dropped.
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      if (i == 0) begin valid_flit_i = 1'b1; data_i = mk(BODY, 0, 0, 0, 'h055); end
      if (i == 1) begin valid_flit_i = 1'b1; data_i = mk(TAIL, 0, 0, 0, 'h056); end
      tick_check();
      if (i >= 1) begin
        chk("t6_empty", 32'(is_empty_o[0]), 32'(1));
        chk("t6_req", 32'(vc_request_o[0]), 32'(0));
      end
      tick_adv();
    end

    random_phase(1500, 60, 70);
    random_phase(600, 80, 10);

    // Asynchronous reset in the middle of traffic.
    rst = 1'b0;
    model_reset();
    clear_inputs();
    tick_check();
    chk("mid_rst_empty", 32'(is_empty_o), 32'({VC_NUM{1'b1}}));
    chk("mid_rst_alloc", 32'(vc_allocatable_o), 32'({VC_NUM{1'b1}}));
    tick_adv();
    rst = 1'b1;

    random_phase(800, 50, 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
